vga_sprite_renderer: RTL and testbench

Parametrised successor to the game's VGA output stage. Integrates the 640x480 sync generator, composites a bird box and NUM_PIPES gapped pipe pairs with fixed priority, and outputs multi-bit RGB. Object positions are captured into shadow registers once per frame to prevent tearing. Sits between the game-logic core and the board VGA connector.

---
 rtl/vga_sprite_renderer.sv | 168 ++++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_renderer.sv
// 640x480-class VGA output stage: sync generator, per-frame shadowed object positions,
// and a two-stage pixel pipeline compositing a bird box over gapped pipe pairs.
module vga_sprite_renderer #(
    parameter int NUM_PIPES = 4,
    parameter int COLOR_W   = 3,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BIRD_HALF = 10,
    parameter int PIPE_W    = 80,
    parameter int GAP_H     = 100,
    parameter logic [3*COLOR_W-1:0] BIRD_RGB = {{COLOR_W{1'b1}}, {2*COLOR_W{1'b0}}},
    parameter logic [3*COLOR_W-1:0] PIPE_RGB = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}},
    parameter logic [3*COLOR_W-1:0] BG_RGB   = {{2*COLOR_W{1'b0}}, COLOR_W'({COLOR_W{1'b1}} >> 1)}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_en,
    input  logic [9:0]              bird_x,
    input  logic [9:0]              bird_y,
    input  logic [10*NUM_PIPES-1:0] pipe_x,
    input  logic [10*NUM_PIPES-1:0] gap_y,
    input  logic [NUM_PIPES-1:0]    pipe_en,
    output logic                    vga_h_sync,
    output logic                    vga_v_sync,
    output logic [COLOR_W-1:0]      vga_r,
    output logic [COLOR_W-1:0]      vga_g,
    output logic [COLOR_W-1:0]      vga_b,
    output logic                    frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] PIPE_W11 = 11'(PIPE_W);
    localparam logic [10:0] GAP_H11  = 11'(GAP_H);
    localparam logic signed [11:0] BH = 12'(BIRD_HALF);

    logic [9:0] h_cnt, v_cnt;
    logic       capture;

    logic [9:0]              sh_bird_x, sh_bird_y;
    logic [10*NUM_PIPES-1:0] sh_pipe_x, sh_gap_y;
    logic [NUM_PIPES-1:0]    sh_pipe_en;

    logic                    bird_hit_c, active_c, hs_c, vs_c;
    logic [NUM_PIPES-1:0]    pipe_hit_c;
    logic signed [11:0]      dh, dv;
    logic [10:0]             h11, v11;

    logic                    bird_hit_p1, active_p1, hs_p1, vs_p1;
    logic [NUM_PIPES-1:0]    pipe_hit_p1;
    logic [3*COLOR_W-1:0]    rgb_p2;
    logic                    hs_p2, vs_p2;

    function automatic logic [3*COLOR_W-1:0] pick_colour(input logic act, input logic bird,
                                                         input logic pipe);
        if (!act)
            return '0;
        if (bird)
            return BIRD_RGB;
        if (pipe)
            return PIPE_RGB;
        return BG_RGB;
    endfunction

    // Stage 0: raster counters and once-per-frame shadow capture
    assign capture    = pix_en && (h_cnt == '0) && (v_cnt == V_ACT);
    assign frame_tick = capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_bird_x  <= '0;
            sh_bird_y  <= '0;
            sh_pipe_x  <= '0;
            sh_gap_y   <= '0;
            sh_pipe_en <= '0;
        end else if (capture) begin
            sh_bird_x  <= bird_x;
            sh_bird_y  <= bird_y;
            sh_pipe_x  <= pipe_x;
            sh_gap_y   <= gap_y;
            sh_pipe_en <= pipe_en;
        end
    end

    // Stage 1: hit tests; widened arithmetic so off-screen objects clip instead of wrapping
    assign h11 = {1'b0, h_cnt};
    assign v11 = {1'b0, v_cnt};
    assign dh  = $signed({2'b00, h_cnt}) - $signed({{2{sh_bird_x[9]}}, sh_bird_x});
    assign dv  = $signed({2'b00, v_cnt}) - $signed({{2{sh_bird_y[9]}}, sh_bird_y});
    assign bird_hit_c = (dh >= -BH) && (dh <= BH) && (dv >= -BH) && (dv <= BH);
    assign active_c   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_c       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    always_comb begin
        pipe_hit_c = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_hit_c[i] = sh_pipe_en[i]
                && (h11 >= {1'b0, sh_pipe_x[10*i +: 10]})
                && (h11 <  {1'b0, sh_pipe_x[10*i +: 10]} + PIPE_W11)
                && ((v11 <  {1'b0, sh_gap_y[10*i +: 10]})
                 || (v11 >= {1'b0, sh_gap_y[10*i +: 10]} + GAP_H11));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bird_hit_p1 <= 1'b0;
            pipe_hit_p1 <= '0;
            active_p1   <= 1'b0;
            hs_p1       <= 1'b1;
            vs_p1       <= 1'b1;
        end else if (pix_en) begin
            bird_hit_p1 <= bird_hit_c;
            pipe_hit_p1 <= pipe_hit_c;
            active_p1   <= active_c;
            hs_p1       <= hs_c;
            vs_p1       <= vs_c;
        end
    end

    // Stage 2: priority colour select, syncs kept aligned with colour
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_p2 <= '0;
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
        end else if (pix_en) begin
            rgb_p2 <= pick_colour(active_p1, bird_hit_p1, |pipe_hit_p1);
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    assign vga_h_sync = hs_p2;
    assign vga_v_sync = vs_p2;
    assign vga_r      = rgb_p2[3*COLOR_W-1 -: COLOR_W];
    assign vga_g      = rgb_p2[2*COLOR_W-1 -: COLOR_W];
    assign vga_b      = rgb_p2[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Scoreboard bench for vga_sprite_renderer on a reduced raster (80x55 total, 64x48 active).
module tb_vga_sprite_renderer;
    localparam int NP = 4;
    localparam int CW = 3;
    localparam int HA = 64, HF = 4, H_SW = 8, HB = 4;
    localparam int VA = 48, VF = 2, V_SW = 2, VB = 3;
    localparam int HT = HA + HF + H_SW + HB;
    localparam int VT = VA + VF + V_SW + VB;
    localparam int FT = HT * VT;
    localparam int BH = 3, PW = 10, GAP = 12;
    localparam logic [8:0] C_BIRD = 9'b111_000_000;
    localparam logic [8:0] C_PIPE = 9'b000_111_000;
    localparam logic [8:0] C_BG   = 9'b000_000_011;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            pix_en = 1'b0;
    logic [9:0]      bird_x = '0, bird_y = '0;
    logic [10*NP-1:0] pipe_x = '0, gap_y = '0;
    logic [NP-1:0]   pipe_en = '0;
    logic            vga_h_sync, vga_v_sync, frame_tick;
    logic [CW-1:0]   vga_r, vga_g, vga_b;

    vga_sprite_renderer #(
        .NUM_PIPES(NP), .COLOR_W(CW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(H_SW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(V_SW), .V_BP(VB),
        .BIRD_HALF(BH), .PIPE_W(PW), .GAP_H(GAP)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y), .pipe_en(pipe_en),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [10:0] out_q[$];
    int          pix_q[$];
    bit          tick_q[$];
    bit          en_seen = 1'b0;
    int          m = 0;

    // Reference state: what the frame in flight was captured from
    int m_bx, m_by;
    int m_px[NP], m_gy[NP];
    bit m_en[NP];

    function automatic bit is_cap(input int p);
        return (p % HT == 0) && ((p / HT) % VT == VA);
    endfunction

    function automatic logic [10:0] pix_exp(input int p);
        int h, v;
        logic hs, vs;
        logic [8:0] rgb;
        bit pipe;
        h = p % HT;
        v = (p / HT) % VT;
        hs = !(h >= HA + HF && h < HA + HF + H_SW);
        vs = !(v >= VA + VF && v < VA + VF + V_SW);
        rgb = '0;
        if (h < HA && v < VA) begin
            pipe = 0;
            for (int i = 0; i < NP; i++)
                if (m_en[i] && h >= m_px[i] && h < m_px[i] + PW &&
                    (v < m_gy[i] || v >= m_gy[i] + GAP))
                    pipe = 1;
            if (h - m_bx <= BH && m_bx - h <= BH && v - m_by <= BH && m_by - v <= BH)
                rgb = C_BIRD;
            else if (pipe)
                rgb = C_PIPE;
            else
                rgb = C_BG;
        end
        return {hs, vs, rgb};
    endfunction

    task automatic model_capture();
        m_bx = int'($signed(bird_x));
        m_by = int'($signed(bird_y));
        for (int i = 0; i < NP; i++) begin
            m_px[i] = int'(pipe_x[10*i +: 10]);
            m_gy[i] = int'(gap_y[10*i +: 10]);
            m_en[i] = pipe_en[i];
        end
    endtask

    task automatic model_reset();
        m = 0;
        m_bx = 0;
        m_by = 0;
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 0;
            m_gy[i] = 0;
            m_en[i] = 0;
        end
    endtask

    task automatic randomize_inputs();
        int t;
        t = int'($urandom_range(0, 79)) - 8;
        bird_x = 10'(t);
        t = int'($urandom_range(0, 63)) - 8;
        bird_y = 10'(t);
        for (int i = 0; i < NP; i++) begin
            pipe_x[10*i +: 10] = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(900, 1023))
                                                             : 10'($urandom_range(0, 70));
            gap_y[10*i +: 10]  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023))
                                                             : 10'($urandom_range(0, 45));
        end
        pipe_en = NP'($urandom);
    endtask

    task automatic frame_inputs(input int f);
        if (f == 0) begin
            bird_x = 10'd20; bird_y = 10'd20;
            pipe_x = '0; gap_y = '0; pipe_en = '0;
        end else if (f == 1) begin
            bird_x = 10'd33; bird_y = 10'd10;
            pipe_x[9:0] = 10'd30; gap_y[9:0] = 10'd15; pipe_en = 4'b0001;
        end else if (f == 2) begin
            bird_x = 10'h3FE; bird_y = 10'd30;
            pipe_x[9:0] = 10'd60; gap_y[9:0] = 10'd40;
            pipe_x[29:20] = 10'd5; gap_y[29:20] = 10'd20; pipe_en = 4'b0101;
        end else begin
            randomize_inputs();
        end
    endtask

    // One clk of stimulus; on a pixel cycle the expected pin state after this edge is queued
    task automatic cyc(input bit en);
        int p;
        @(posedge clk);
        #1;
        pix_en = en;
        if (en) begin
            p = m;
            m++;
            if (p % HT == 0 && (p / HT) % VT == 10)
                frame_inputs(p / FT);
            else if (p / FT >= 3 && $urandom_range(0, 499) == 0)
                randomize_inputs();
            out_q.push_back(m == 1 ? 11'b11_000000000 : pix_exp(m - 2));
            pix_q.push_back(m - 2);
            tick_q.push_back(is_cap(p));
            if (is_cap(p))
                model_capture();
        end
    endtask

    task automatic check_reset_outs(input string name);
        checks++;
        if ({vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_tick} !== 12'b11_000000000_0) begin
            failures++;
            $display("FAIL %s actual hs=%b vs=%b rgb=%h tick=%b required hs=1 vs=1 rgb=0 tick=0",
                     name, vga_h_sync, vga_v_sync, {vga_r, vga_g, vga_b}, frame_tick);
        end
    endtask

    always @(posedge clk) en_seen <= pix_en && reset;

    always @(negedge clk) begin
        bit exp_t;
        logic [10:0] exp_o;
        int px;
        if (reset) begin
            exp_t = 1'b0;
            if (pix_en) begin
                if (tick_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tick_queue actual=empty required=entry");
                end else begin
                    exp_t = tick_q.pop_front();
                end
            end
            checks++;
            if (frame_tick !== exp_t) begin
                failures++;
                $display("FAIL frame_tick pixel=%0d actual=%b required=%b", m - 1, frame_tick, exp_t);
            end
            if (en_seen) begin
                checks++;
                if (out_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_queue actual=empty required=entry");
                end else begin
                    exp_o = out_q.pop_front();
                    px = pix_q.pop_front();
                    if ({vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b} !== exp_o) begin
                        failures++;
                        $display("FAIL pixel p=%0d h=%0d v=%0d actual=%b_%b_%h required=%b_%b_%h",
                                 px, px % HT, (px / HT) % VT, vga_h_sync, vga_v_sync,
                                 {vga_r, vga_g, vga_b}, exp_o[10], exp_o[9], exp_o[8:0]);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            pix_en = (i % 4 == 0);
            @(negedge clk);
            check_reset_outs("reset_hold");
        end
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        reset = 1'b1;

        while (m < FT + 200) begin
            cyc(0); cyc(0); cyc(0); cyc(1);
        end
        while (m < 5 * FT)
            cyc($urandom_range(0, 3) != 0);

        while ((m / HT) % VT != 24 || m % HT != 30)
            cyc(1);
        cyc(0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_midframe");
        checks++;
        if (out_q.size() != 0 || tick_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d/%0d required=0/0", out_q.size(), tick_q.size());
        end
        out_q.delete(); pix_q.delete(); tick_q.delete();
        @(posedge clk);
        #1;
        pix_en = 1'b1;
        @(negedge clk);
        check_reset_outs("reset_pix_en");
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        reset = 1'b1;
        model_reset();

        while (m < FT + FT / 2)
            cyc($urandom_range(0, 3) != 0);
        cyc(0);
        cyc(0);
        checks++;
        if (out_q.size() != 0) begin
            failures++;
            $display("FAIL final_drain actual=%0d required=0", out_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
